div_sequencer: RTL and testbench

Iterative radix-2 division sequencer for the B-lane divide/modulo unit in the EX stage. It captures operands on an EX-stage request and raises `stall_div` while it runs a fixed 32-iteration restoring division. It applies signed correction, then publishes quotient and remainder to the MEM-stage writeback mux only when the divide instruction advances EX→MEM. It replaces the free-running divider handshake with an explicit FSM that tolerates dcache stalls, branch flushes and back-to-back divides.

---
 rtl/div_sequencer_if.sv | 23 ++
 rtl/div_sequencer.sv | 86 ++++++++
 tb/tb_div_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// EX-stage B-lane divide request/result bundle between pipeline control and div_sequencer.
interface div_sequencer_if #(parameter int WIDTH = 32);
    logic             div_en;
    logic             div_signed;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             pipe_stall;
    logic             flush;
    logic             stall_div;
    logic             div_busy;
    logic [WIDTH-1:0] MEM_div_quo;
    logic [WIDTH-1:0] MEM_div_rem;

    modport master (
        output div_en, div_signed, div_x, div_y, pipe_stall, flush,
        input  stall_div, div_busy, MEM_div_quo, MEM_div_rem
    );

    modport slave (
        input  div_en, div_signed, div_x, div_y, pipe_stall, flush,
        output stall_div, div_busy, MEM_div_quo, MEM_div_rem
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for the B lane; results are published to MEM
// only on the cycle the divide instruction leaves EX.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave dif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ay;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic             qneg;
    logic             rneg;
    logic [WIDTH-1:0] mem_quo;
    logic [WIDTH-1:0] mem_rem;

    logic             xs, ys;
    logic [WIDTH-1:0] ax_in, ay_in;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Magnitudes are taken as unsigned, so |-2^(W-1)| needs no special handling.
    always_comb begin
        xs      = dif.div_signed & dif.div_x[WIDTH-1];
        ys      = dif.div_signed & dif.div_y[WIDTH-1];
        ax_in   = xs ? -dif.div_x : dif.div_x;
        ay_in   = ys ? -dif.div_y : dif.div_y;
        rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = rem_sh - {1'b0, ay};
        quo_fix = qneg ? -quo : quo;
        rem_fix = rneg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ay      <= '0;
            quo     <= '0;
            rem     <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            mem_quo <= '0;
            mem_rem <= '0;
        end else if (dif.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (dif.div_en) begin
                    ay    <= ay_in;
                    quo   <= ax_in;
                    rem   <= '0;
                    qneg  <= xs ^ ys;
                    rneg  <= xs;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    // trial MSB set means the subtraction went negative: restore.
                    rem <= trial[WIDTH] ? rem_sh : trial;
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt == CW'(WIDTH - 1)) state <= DONE;
                    else                       cnt   <= cnt + CW'(1);
                end
                DONE: if (!dif.pipe_stall) begin
                    mem_quo <= quo_fix;
                    mem_rem <= rem_fix;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dif.stall_div   = ((state == IDLE) & dif.div_en & ~dif.flush) | (state == CALC);
    assign dif.div_busy    = (state != IDLE);
    assign dif.MEM_div_quo = mem_quo;
    assign dif.MEM_div_rem = mem_rem;
endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed checks of div_sequencer against an arithmetic reference.
module tb_div_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_sequencer_if #(.WIDTH(W)) dif ();
    div_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .dif(dif));

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] pq = '0, pr = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        logic signed [W-1:0] sx, sy;
        sx = x;
        sy = y;
        if (y == '0) begin
            q = (sgn && x[W-1]) ? W'(1) : '1;
            r = x;
        end else if (!sgn) begin
            q = x / y;
            r = x % y;
        end else if (x == 32'h8000_0000 && y == '1) begin
            q = x;
            r = '0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
    endfunction

    // Called at posedge+1 of the request cycle; returns at posedge+1 of the cycle after publication.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                          input int nstall, input bit keep);
        logic [W-1:0] eq, er;
        int n;
        dif.div_en     = 1'b1;
        dif.div_x      = x;
        dif.div_y      = y;
        dif.div_signed = sgn;
        dif.pipe_stall = 1'b0;
        model(x, y, sgn, eq, er);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!dif.stall_div) break;
            n++;
            @(posedge clk); #1;
        end
        chk("stall_len", n, 33);
        chk("busy_done", dif.div_busy, 1);
        chk("hold_quo", dif.MEM_div_quo, pq);
        chk("hold_rem", dif.MEM_div_rem, pr);
        dif.pipe_stall = (nstall > 0);
        for (int s = 0; s < nstall; s++) begin
            @(posedge clk); #1;
            if (s == nstall - 1) dif.pipe_stall = 1'b0;
            chk("stl_quo", dif.MEM_div_quo, pq);
            chk("stl_stall_div", dif.stall_div, 0);
        end
        @(posedge clk); #1;
        chk("quo", dif.MEM_div_quo, eq);
        chk("rem", dif.MEM_div_rem, er);
        chk("busy_idle", dif.div_busy, 0);
        pq = eq;
        pr = er;
        if (!keep) dif.div_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] x, y;
        dif.div_en = 1'b0; dif.div_signed = 1'b0; dif.div_x = '0; dif.div_y = '0;
        dif.pipe_stall = 1'b0; dif.flush = 1'b0;
        #2;
        chk("rst_stall", dif.stall_div, 0);
        chk("rst_busy", dif.div_busy, 0);
        chk("rst_quo", dif.MEM_div_quo, 0);
        chk("rst_rem", dif.MEM_div_rem, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Flush in cycle 10 of a 100/7 op: nothing published.
        dif.div_en = 1'b1; dif.div_x = 100; dif.div_y = 7; dif.div_signed = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        dif.flush = 1'b1;
        @(negedge clk);
        chk("flush_k_stall", dif.stall_div, 1);
        @(posedge clk); #1;
        dif.flush = 1'b0; dif.div_en = 1'b0;
        @(negedge clk);
        chk("flush_stall", dif.stall_div, 0);
        chk("flush_busy", dif.div_busy, 0);
        chk("flush_quo", dif.MEM_div_quo, pq);
        chk("flush_rem", dif.MEM_div_rem, pr);
        @(posedge clk); #1;

        run_op(100, 7, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFF9, 2, 1'b1, 0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        run_op(5, 0, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFFB, 0, 1'b1, 0, 1'b0);
        run_op(100, 7, 1'b0, 3, 1'b0);
        run_op(100, 7, 1'b0, 0, 1'b1);
        run_op(9, 4, 1'b0, 0, 1'b0);

        // Reset in the middle of CALC.
        dif.div_en = 1'b1; dif.div_x = 1000; dif.div_y = 3;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; dif.div_en = 1'b0;
        #1;
        chk("mrst_quo", dif.MEM_div_quo, 0);
        chk("mrst_rem", dif.MEM_div_rem, 0);
        chk("mrst_busy", dif.div_busy, 0);
        chk("mrst_stall", dif.stall_div, 0);
        pq = '0; pr = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_op(1000, 3, 1'b0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 7))
                0:       y = '0;
                1:       y = '1;
                2:       y = W'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            run_op(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   (i != 24) && ($urandom_range(0, 1) == 1));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
